cond_unit_mc: RTL and testbench

//  Multi-cycle condition logic, directly downstream of decode.
//  - Holds the architectural NZCV flags.
//  - Evaluates the instruction's Cond field once per instruction, in the DECODE state.
//  - Gates decode's PCS/NextPC/RegW/MemW/FlagW into the final PCWrite/RegWrite/MemWrite and flag-write enables.
//  - Drives the datapath PC, register file and memory write strobes.

---
 rtl/cond_unit_mc.sv | 102 ++++++++++
 tb/tb_cond_unit_mc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit_mc.sv
// rtl/cond_unit_mc.sv - multi-cycle condition unit: NZCV flags, latched condition result, write gating
//
// Purpose: holds the architectural NZCV flags, evaluates the instruction's
// condition field once per instruction (in DECODE) and gates decode's write
// requests into the final PC / register file / memory write enables.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   state[3:0]           current main FSM state
//   Cond[3:0]            instruction condition field
//   ALUFlags[3:0]        {N,Z,C,V} produced by the ALU this cycle
//   FlagW[1:0]           [1] write N,Z  [0] write C,V
//   PCS, NextPC          PC-sourced write request, unconditional PC+4 update
//   RegW, MemW           register / memory write requests
//   PCWrite, RegWrite,   gated write enables
//   MemWrite
//   Flags[3:0]           architectural {N,Z,C,V}
//   CondEx               latched condition result for the current instruction
module cond_unit_mc #(
  parameter logic [3:0] DECODE_STATE = 4'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] state,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       ce;
  logic       n_f, z_f, c_f, v_f;

  // Condition is evaluated against the registered flags only, so an ALU
  // result in flight never influences the decision for its own instruction.
  always_comb begin
    {n_f, z_f, c_f, v_f} = flags_q;
    ce = 1'b1;
    case (Cond)
      4'h0: ce = z_f;
      4'h1: ce = ~z_f;
      4'h2: ce = c_f;
      4'h3: ce = ~c_f;
      4'h4: ce = n_f;
      4'h5: ce = ~n_f;
      4'h6: ce = v_f;
      4'h7: ce = ~v_f;
      4'h8: ce = c_f & ~z_f;
      4'h9: ce = ~c_f | z_f;
      4'hA: ce = (n_f == v_f);
      4'hB: ce = (n_f != v_f);
      4'hC: ce = ~z_f & (n_f == v_f);
      4'hD: ce = z_f | (n_f != v_f);
      default: ce = 1'b1;  // AL, and 4'hF treated as AL
    endcase
  end

  always_comb begin
    cond_ex_d = cond_ex_q;
    if (state == DECODE_STATE) begin
      cond_ex_d = ce;
    end
  end

  // The two flag halves have independent enables and may update together.
  always_comb begin
    flags_d = flags_q;
    if (FlagW[1] && cond_ex_q) begin
      flags_d[3:2] = ALUFlags[3:2];
    end
    if (FlagW[0] && cond_ex_q) begin
      flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign PCWrite  = NextPC | (PCS & cond_ex_q);
  assign RegWrite = RegW & cond_ex_q;
  assign MemWrite = MemW & cond_ex_q;
  assign Flags    = flags_q;
  assign CondEx   = cond_ex_q;

endmodule

// File: tb/tb_cond_unit_mc.sv
// tb/tb_cond_unit_mc.sv - self-checking bench for cond_unit_mc
module tb_cond_unit_mc;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_EXEC   = 4'd2;
  localparam logic [3:0] ST_MEMWR  = 4'd4;
  localparam logic [3:0] ST_ALUWB  = 4'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state, Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW;
  logic       PCWrite, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;

  int checks   = 0;
  int failures = 0;

  cond_unit_mc #(.DECODE_STATE(ST_DECODE)) dut (
    .clk(clk), .reset(reset), .state(state), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .CondEx(CondEx)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] st, cond, alu;
    logic [1:0] fw;
    logic       pcs, npc, rw, mw;
    logic       e_pcw, e_rw, e_mw;
    logic [3:0] e_flags;
    logic       e_cex;
  } vec_t;

  // Reference condition table written straight from the mnemonic rules.
  function automatic logic ref_ce(input logic [3:0] c, input logic [3:0] f);
    int n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0:  return z == 1;
      1:  return z == 0;
      2:  return cy == 1;
      3:  return cy == 0;
      4:  return n == 1;
      5:  return n == 0;
      6:  return v == 1;
      7:  return v == 0;
      8:  return cy == 1 && z == 0;
      9:  return cy == 0 || z == 1;
      10: return n == v;
      11: return n != v;
      12: return z == 0 && n == v;
      13: return z == 1 || n != v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] st, input logic [3:0] c, input logic [3:0] alu,
                       input logic [1:0] fw, input logic pcs, input logic npc,
                       input logic rw, input logic mw);
    state = st; Cond = c; ALUFlags = alu; FlagW = fw;
    PCS = pcs; NextPC = npc; RegW = rw; MemW = mw;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  vec_t vecs[$];
  logic [3:0] m_flags;
  logic       m_cex;

  initial begin
    // st, cond, alu, fw, pcs, npc, rw, mw | pcw, rw, mw, flags, cex
    vecs.push_back('{ST_FETCH,  4'hE, 4'h0, 2'b00, 0, 1, 1, 0, 1, 0, 0, 4'b0000, 0});
    vecs.push_back('{ST_DECODE, 4'hE, 4'h0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0});
    vecs.push_back('{ST_ALUWB,  4'hE, 4'h0, 2'b00, 0, 0, 1, 0, 0, 1, 0, 4'b0000, 1});
    vecs.push_back('{ST_EXEC,   4'hE, 4'hB, 2'b10, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1});
    vecs.push_back('{ST_FETCH,  4'hE, 4'h4, 2'b10, 0, 1, 0, 0, 1, 0, 0, 4'b1000, 1});
    vecs.push_back('{ST_DECODE, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 1});
    vecs.push_back('{ST_MEMWR,  4'h0, 4'h0, 2'b00, 0, 0, 0, 1, 0, 0, 1, 4'b0100, 1});
    vecs.push_back('{ST_DECODE, 4'h1, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 1});
    vecs.push_back('{ST_MEMWR,  4'h1, 4'h0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 4'b0100, 0});
    vecs.push_back('{ST_EXEC,   4'h1, 4'hF, 2'b11, 1, 0, 0, 0, 0, 0, 0, 4'b0100, 0});
    vecs.push_back('{ST_FETCH,  4'h1, 4'h0, 2'b00, 1, 1, 0, 0, 1, 0, 0, 4'b0100, 0});
    vecs.push_back('{ST_DECODE, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 0});
    vecs.push_back('{ST_EXEC,   4'h0, 4'h0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 1});
    vecs.push_back('{ST_ALUWB,  4'h0, 4'h0, 2'b00, 1, 1, 1, 0, 1, 1, 0, 4'b0000, 1});
    vecs.push_back('{ST_DECODE, 4'h1, 4'h4, 2'b10, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1});
    vecs.push_back('{ST_DECODE, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 1});
    vecs.push_back('{ST_DECODE, 4'h1, 4'h0, 2'b00, 1, 0, 0, 0, 1, 0, 0, 4'b0100, 1});
    vecs.push_back('{ST_ALUWB,  4'h1, 4'h0, 2'b00, 1, 0, 1, 1, 0, 0, 0, 4'b0100, 0});

    drive(ST_FETCH, 4'hE, 4'h0, 2'b00, 0, 1, 1, 1);
    reset = 1'b1;
    #1;
    chk("reset_flags", Flags, 4'b0000);
    chk("reset_cex", {3'b0, CondEx}, 4'h0);
    chk("reset_pcwrite", {3'b0, PCWrite}, 4'h1);
    chk("reset_regwrite", {3'b0, RegWrite}, 4'h0);
    chk("reset_memwrite", {3'b0, MemWrite}, 4'h0);
    @(negedge clk);
    do_reset();

    // Directed table
    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].cond, vecs[i].alu, vecs[i].fw,
            vecs[i].pcs, vecs[i].npc, vecs[i].rw, vecs[i].mw);
      #1;
      chk($sformatf("vec%0d_pcwrite", i), {3'b0, PCWrite}, {3'b0, vecs[i].e_pcw});
      chk($sformatf("vec%0d_regwrite", i), {3'b0, RegWrite}, {3'b0, vecs[i].e_rw});
      chk($sformatf("vec%0d_memwrite", i), {3'b0, MemWrite}, {3'b0, vecs[i].e_mw});
      chk($sformatf("vec%0d_flags", i), Flags, vecs[i].e_flags);
      chk($sformatf("vec%0d_condex", i), {3'b0, CondEx}, {3'b0, vecs[i].e_cex});
      tick();
    end

    // Full Cond x Flags sweep
    for (int f = 0; f < 16; f++) begin
      drive(ST_DECODE, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
      tick();
      drive(ST_EXEC, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0);
      tick();
      chk($sformatf("sweep_setflags_%0d", f), Flags, 4'(f));
      for (int c = 0; c < 16; c++) begin
        drive(ST_DECODE, 4'(c), 4'(~f), 2'b00, 0, 0, 0, 0);
        tick();
        chk($sformatf("sweep_c%0d_f%0d", c, f), {3'b0, CondEx}, {3'b0, ref_ce(4'(c), 4'(f))});
      end
    end

    // Reset pulse in the middle of ALUWB
    drive(ST_DECODE, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    tick();
    drive(ST_EXEC, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0);
    tick();
    drive(ST_ALUWB, 4'hE, 4'h0, 2'b00, 1, 0, 1, 1);
    #1;
    chk("midwb_regwrite_before", {3'b0, RegWrite}, 4'h1);
    reset = 1'b1;
    #1;
    chk("midwb_regwrite_after", {3'b0, RegWrite}, 4'h0);
    chk("midwb_memwrite_after", {3'b0, MemWrite}, 4'h0);
    chk("midwb_pcwrite_after", {3'b0, PCWrite}, 4'h0);
    chk("midwb_flags_after", Flags, 4'h0);
    #1;
    reset = 1'b0;
    @(negedge clk);
    drive(ST_ALUWB, 4'hE, 4'h0, 2'b00, 0, 0, 1, 0);
    tick();
    chk("postreset_regwrite", {3'b0, RegWrite}, 4'h0);

    // Randomized run against the reference model
    do_reset();
    m_flags = 4'b0000;
    m_cex   = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic [3:0] st, c, alu, nf;
      logic [1:0] fw;
      logic pcs, npc, rw, mw, ncex;
      st  = ($urandom_range(0, 2) == 0) ? ST_DECODE : 4'($urandom_range(0, 10));
      c   = 4'($urandom);
      alu = 4'($urandom);
      fw  = 2'($urandom);
      pcs = 1'($urandom); npc = 1'($urandom); rw = 1'($urandom); mw = 1'($urandom);
      drive(st, c, alu, fw, pcs, npc, rw, mw);
      #1;
      chk("rand_pcwrite", {3'b0, PCWrite}, {3'b0, npc || (pcs && m_cex)});
      chk("rand_regwrite", {3'b0, RegWrite}, {3'b0, rw && m_cex});
      chk("rand_memwrite", {3'b0, MemWrite}, {3'b0, mw && m_cex});
      chk("rand_flags", Flags, m_flags);
      chk("rand_condex", {3'b0, CondEx}, {3'b0, m_cex});
      nf = m_flags;
      if (m_cex && fw[1]) nf[3:2] = alu[3:2];
      if (m_cex && fw[0]) nf[1:0] = alu[1:0];
      ncex = (st == ST_DECODE) ? ref_ce(c, m_flags) : m_cex;
      tick();
      m_flags = nf;
      m_cex   = ncex;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
